// File: rtl/us_capture_pkg.sv
// us_capture_pkg: shared types and helpers for the ultrasound frame packer
package us_capture_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

    // Sign-extend the low adc_w bits of sample to 16 bits
    function automatic logic [15:0] sext16(input logic [15:0] sample, input int adc_w);
        logic signed [15:0] t;
        t = sample << (16 - adc_w);
        return t >>> (16 - adc_w);
    endfunction

endpackage

// File: rtl/us_sync_fifo.sv
// us_sync_fifo: single-clock FIFO with registered output, occupancy count and sync flush
module us_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      din_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  do_pop, do_push;

    assign count_o = count_q;
    assign dout_o  = dout_q;
    assign full_o  = count_q[DEPTH_LOG2];
    assign empty_o = count_q == '0;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    // A push into a full FIFO is accepted when a pop frees a slot on the same edge
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    // Next pointer, count and output word; flush empties without touching the held output
    always_comb begin
        wptr_d  = flush_i ? '0 : wptr_q + DEPTH_LOG2'(do_push);
        rptr_d  = flush_i ? '0 : rptr_q + DEPTH_LOG2'(do_pop);
        count_d = flush_i ? '0 : count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        dout_d  = do_pop ? mem_q[rptr_q] : dout_q;
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    // Pointer, count and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: rtl/us_frame_packer_r32.sv
// us_frame_packer_r32: triggered ADC frame capture, 2-sample packing into 32-bit words for the Xillybus read pipe
module us_frame_packer_r32
    import us_capture_pkg::*;
#(
    parameter int ADC_W       = 12,
    parameter int DEPTH_LOG2  = 9,
    parameter int FRAME_WORDS = 1024
) (
    input  logic              bus_clk_w,
    input  logic              bus_rst_n_w,
    input  logic [ADC_W-1:0]  adc_data_w,
    input  logic              adc_valid_w,
    input  logic              trigger_w,
    input  logic              user_r_read_32_open_w,
    input  logic              user_r_read_32_rden_w,
    output logic [WORD_W-1:0] user_r_read_32_data_w,
    output logic              user_r_read_32_empty_w,
    output logic              user_r_read_32_eof_w,
    output logic              overflow_w,
    output logic              frame_active_w
);

    localparam int CW = $clog2(FRAME_WORDS + 1);

    state_t              state_q, state_d;
    logic                half_q, half_d;
    logic [15:0]         low_q, low_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                eof_q, eof_d;
    logic                push, flush, pop, f_full, f_empty;
    logic [DEPTH_LOG2:0] f_count;
    logic [15:0]         sample;

    assign sample                 = sext16(16'(adc_data_w), ADC_W);
    assign pop                    = user_r_read_32_rden_w & ~f_empty;
    assign user_r_read_32_empty_w = f_empty;
    assign user_r_read_32_eof_w   = eof_q;
    assign overflow_w             = ovf_q;
    assign frame_active_w         = state_q == CAPTURE;

    us_sync_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (bus_clk_w),
        .rst_ni  (bus_rst_n_w),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (user_r_read_32_rden_w),
        .din_i   ({sample, low_q}),
        .dout_o  (user_r_read_32_data_w),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    // Frame FSM and packer; closing the file overrides every state and wipes the frame
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (!user_r_read_32_open_w) begin
            state_d = IDLE;
            flush   = 1'b1;
            half_d  = 1'b0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = trigger_w ? CAPTURE : ARMED;
                CAPTURE: begin
                    if (adc_valid_w && !half_q) begin
                        low_d  = sample;
                        half_d = 1'b1;
                    end else if (adc_valid_w) begin
                        push   = 1'b1;
                        half_d = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                        ovf_d  = ovf_q | (f_full & ~pop);
                        state_d = (cnt_d == CW'(FRAME_WORDS)) ? DRAIN : CAPTURE;
                    end
                end
                DRAIN:   state_d = (f_count == '0 || (f_count == (DEPTH_LOG2+1)'(1) && pop)) ? DONE : DRAIN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
        eof_d = state_d == DONE;
    end

    // Control state registers
    always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
        if (!bus_rst_n_w) begin
            state_q <= IDLE;
            half_q  <= 1'b0;
            low_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            low_q   <= low_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            eof_q   <= eof_d;
        end
    end

endmodule

// File: tb/tb_us_frame_packer_r32.sv
// tb_us_frame_packer_r32: directed scenario bench for the frame packer (ADC_W=12, 4-word FIFO, 8-word frames)
module tb_us_frame_packer_r32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adc = '0;
    logic        valid = 1'b0, trig = 1'b0, open = 1'b0, rden = 1'b0;
    logic [31:0] data;
    logic        empty, eof, ovf, active;
    int          errors = 0;
    int          checks = 0;

    logic [11:0] smp [16] = '{12'h001, 12'hFFF, 12'h7FF, 12'h800, 12'h123, 12'h456, 12'hABC, 12'h000,
                              12'h555, 12'hAAA, 12'h801, 12'h7FE, 12'h100, 12'hF00, 12'h3C3, 12'hC3C};
    logic [31:0] wexp [8] = '{32'hFFFF0001, 32'hF80007FF, 32'h04560123, 32'h0000FABC,
                              32'hFAAA0555, 32'h07FEF801, 32'hFF000100, 32'hFC3C03C3};

    us_frame_packer_r32 #(.ADC_W(12), .DEPTH_LOG2(2), .FRAME_WORDS(8)) dut (
        .bus_clk_w              (clk),
        .bus_rst_n_w            (rst_n),
        .adc_data_w             (adc),
        .adc_valid_w            (valid),
        .trigger_w              (trig),
        .user_r_read_32_open_w  (open),
        .user_r_read_32_rden_w  (rden),
        .user_r_read_32_data_w  (data),
        .user_r_read_32_empty_w (empty),
        .user_r_read_32_eof_w   (eof),
        .overflow_w             (ovf),
        .frame_active_w         (active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({data, empty, eof, ovf, active} !== {32'h0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_vals: got %h/%b%b%b%b exp 00000000/1000", data, empty, eof, ovf, active);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rden_empty_armed();
        open = 1'b1;
        step();
        rden = 1'b1;
        step();
        step();
        rden = 1'b0;
        step();
        checks++;
        if ({data, empty, active} !== {32'h0, 2'b10}) begin
            errors++;
            $display("FAIL rden_empty: got %h/%b%b exp 00000000/10", data, empty, active);
        end
    endtask

    task automatic test_full_with_pop();
        int idx = 0;
        logic pend;
        trig = 1'b1; valid = 1'b1; adc = 12'h123;
        step();
        trig = 1'b0;
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL active_capture: got %b exp 1", active);
        end
        for (int i = 0; i < 16; i++) begin
            adc = smp[i]; valid = 1'b1; rden = (i >= 9);
            pend = rden & ~empty;
            step();
            if (i == 0) begin
                checks++;
                if (empty !== 1'b1) begin errors++; $display("FAIL empty_after_half: got %b exp 1", empty); end
            end
            if (i == 1) begin
                checks++;
                if (empty !== 1'b0) begin errors++; $display("FAIL empty_after_push: got %b exp 0", empty); end
            end
            if (pend) begin
                checks++;
                if (data !== wexp[idx]) begin errors++; $display("FAIL fullpop_word%0d: got %h exp %h", idx, data, wexp[idx]); end
                idx++;
            end
        end
        valid = 1'b0;
        for (int c = 0; c < 10 && idx < 8; c++) begin
            rden = 1'b1;
            pend = ~empty;
            step();
            if (pend) begin
                checks++;
                if (data !== wexp[idx]) begin errors++; $display("FAIL fullpop_word%0d: got %h exp %h", idx, data, wexp[idx]); end
                idx++;
            end
        end
        rden = 1'b0;
        checks++;
        if (idx != 8) begin errors++; $display("FAIL fullpop_count: got %0d exp 8", idx); end
        checks++;
        if ({empty, eof, ovf, active} !== 4'b1100) begin
            errors++;
            $display("FAIL fullpop_end: got %b%b%b%b exp 1100", empty, eof, ovf, active);
        end
        trig = 1'b1;
        step();
        step();
        trig = 1'b0;
        checks++;
        if ({empty, eof, active} !== 3'b110) begin
            errors++;
            $display("FAIL done_ignores_trig: got %b%b%b exp 110", empty, eof, active);
        end
    endtask

    task automatic test_overflow();
        int idx = 0;
        logic pend;
        open = 1'b0;
        step();
        checks++;
        if ({empty, eof, ovf} !== 3'b100) begin
            errors++;
            $display("FAIL close_after_done: got %b%b%b exp 100", empty, eof, ovf);
        end
        open = 1'b1;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 0; i < 16; i++) begin
            adc = smp[i]; valid = 1'b1;
            step();
            if (i == 7) begin
                checks++;
                if ({ovf, empty} !== 2'b00) begin errors++; $display("FAIL ovf_at_full: got %b%b exp 00", ovf, empty); end
            end
        end
        valid = 1'b0;
        checks++;
        if ({ovf, active, empty, eof} !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_drain: got %b%b%b%b exp 1000", ovf, active, empty, eof);
        end
        for (int c = 0; c < 10 && idx < 4; c++) begin
            rden = 1'b1;
            pend = ~empty;
            step();
            if (pend) begin
                checks++;
                if (data !== wexp[idx]) begin errors++; $display("FAIL ovf_word%0d: got %h exp %h", idx, data, wexp[idx]); end
                idx++;
            end
        end
        rden = 1'b0;
        checks++;
        if ({idx == 4, empty, eof, ovf} !== 4'b1111) begin
            errors++;
            $display("FAIL ovf_end: got n=%0d %b%b%b exp n=4 111", idx, empty, eof, ovf);
        end
    endtask

    task automatic test_streamed_frame(input string tag);
        int idx = 0;
        logic pend;
        trig = 1'b1; valid = 1'b1; adc = 12'h123;
        step();
        trig = 1'b0;
        for (int i = 0; i < 16; i++) begin
            adc = smp[i]; valid = 1'b1; rden = 1'b1;
            pend = ~empty;
            step();
            if (pend) begin
                checks++;
                if (data !== wexp[idx]) begin errors++; $display("FAIL %s_word%0d: got %h exp %h", tag, idx, data, wexp[idx]); end
                idx++;
            end
        end
        valid = 1'b0;
        for (int c = 0; c < 10 && idx < 8; c++) begin
            pend = ~empty;
            step();
            if (pend) begin
                checks++;
                if (data !== wexp[idx]) begin errors++; $display("FAIL %s_word%0d: got %h exp %h", tag, idx, data, wexp[idx]); end
                idx++;
            end
        end
        rden = 1'b0;
        checks++;
        if ({idx == 8, empty, eof, ovf} !== 4'b1110) begin
            errors++;
            $display("FAIL %s_end: got n=%0d %b%b%b exp n=8 110", tag, idx, empty, eof, ovf);
        end
    endtask

    task automatic test_close_mid();
        open = 1'b0;
        step();
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL close_clears_ovf: got %b exp 0", ovf); end
        open = 1'b1;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 8; i < 15; i++) begin
            adc = smp[i]; valid = 1'b1;
            step();
        end
        valid = 1'b0;
        open = 1'b0;
        step();
        checks++;
        if ({empty, eof, ovf, active} !== 4'b1000) begin
            errors++;
            $display("FAIL close_mid: got %b%b%b%b exp 1000", empty, eof, ovf, active);
        end
        open = 1'b1;
        step();
        rden = 1'b1;
        step();
        step();
        rden = 1'b0;
        checks++;
        if ({data, empty} !== {wexp[3], 1'b1}) begin
            errors++;
            $display("FAIL armed_rden_hold: got %h/%b exp %h/1", data, empty, wexp[3]);
        end
        test_streamed_frame("reopen");
    endtask

    task automatic test_reset_mid();
        open = 1'b0;
        step();
        open = 1'b1;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 8; i < 11; i++) begin
            adc = smp[i]; valid = 1'b1;
            step();
        end
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data, empty, eof, ovf, active} !== {32'h0, 4'b1000}) begin
            errors++;
            $display("FAIL async_reset: got %h/%b%b%b%b exp 00000000/1000", data, empty, eof, ovf, active);
        end
        step();
        rst_n = 1'b1;
        step();
        test_streamed_frame("postrst");
    endtask

    initial begin
        test_reset();
        test_rden_empty_armed();
        test_full_with_pop();
        test_overflow();
        test_close_mid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
